probe_capture: RTL and testbench

PROBE_CAPTURE -- requirements
Module: probe_capture

---
 rtl/probe_capture_pkg.sv | 19 +
 rtl/probe_capture_ram.sv | 31 +++
 rtl/probe_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_probe_capture.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_capture_pkg.sv
// Shared types for the probe capture block: FSM state and trigger mode encodings.
package probe_capture_pkg;

  // Encodings are visible on the state port, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    WAIT = 2'd2,
    POST = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LEVEL     = 2'd0,
    EDGE      = 2'd1,
    CHANGE    = 2'd2,
    IMMEDIATE = 2'd3
  } trig_mode_e;

endpackage

// File: rtl/probe_capture_ram.sv
// Sample buffer: simple dual-port RAM, one write port and one registered read port.
// Written in the plain form that synthesis tools map onto block RAM, so there is
// deliberately no reset on the memory or on the read register.
module probe_capture_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/probe_capture.sv
// Logic-analyser style probe capture: trigger evaluation, capture FSM and
// circular-buffer address arithmetic around a single sample RAM.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not capturing; done marks a finished capture ready for readout
// PRE   | filling the pre-trigger window, trigger ignored
// WAIT  | writing continuously (wrapping), evaluating the trigger
// POST  | writing the samples that follow the trigger sample
module probe_capture
  import probe_capture_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] probe,
  input  logic              arm,
  input  logic              abort,
  input  logic [AW-1:0]     pre_trig,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [1:0]        trig_mode,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              done,
  output logic [AW-1:0]     trig_pos
);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wptr, tptr;
  logic [AW-1:0]     pre_q;
  logic [DATA_W-1:0] mask_q, value_q;
  trig_mode_e        mode_q;
  logic [DATA_W-1:0] probe_q;
  logic              lvl_q;
  logic              done_q, trig_q;
  logic              rd_ok;

  logic              lvl_now;
  logic              trig_hit;
  logic              cap_active;
  logic              arm_ok;
  logic              trig_take;
  logic              finish;
  logic [AW-1:0]     post_len;
  logic [AW-1:0]     base;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] ram_q;

  assign cap_active = (state_q != IDLE);
  assign lvl_now    = (((probe ^ value_q) & mask_q) == '0);

  // Samples after the trigger sample: DEPTH-1-pre_trig, i.e. the bitwise
  // complement of pre_trig within AW bits.
  assign post_len = ~pre_q;

  // Oldest sample sits pre_trig entries behind the trigger sample.
  assign base  = tptr - pre_q;
  assign raddr = base + rd_addr;

  // Trigger condition for the latched mode.
  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      LEVEL:     trig_hit = lvl_now;
      EDGE:      trig_hit = lvl_now && !lvl_q;
      CHANGE:    trig_hit = |((probe ^ probe_q) & mask_q);
      IMMEDIATE: trig_hit = 1'b1;
      default:   trig_hit = 1'b0;
    endcase
  end

  // Next-state logic. cnt is a down-counter holding the remaining cycles of
  // PRE/POST minus one, so terminal count is zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arm_ok    = 1'b0;
    trig_take = 1'b0;
    finish    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            arm_ok = 1'b1;
            if (pre_trig == '0) begin
              state_d = WAIT;
            end else begin
              state_d = PRE;
              cnt_d   = pre_trig - AW'(1);
            end
          end
        end
        PRE: begin
          if (cnt_q == '0) begin
            state_d = WAIT;
          end else begin
            cnt_d = cnt_q - AW'(1);
          end
        end
        WAIT: begin
          if (trig_hit) begin
            trig_take = 1'b1;
            // A full pre-trigger window leaves nothing to write afterwards.
            if (post_len == '0) begin
              state_d = IDLE;
              finish  = 1'b1;
            end else begin
              state_d = POST;
              cnt_d   = post_len - AW'(1);
            end
          end
        end
        POST: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            cnt_d = cnt_q - AW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write pointer advances with every captured sample; trigger pointer
  // remembers where the trigger sample landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      tptr <= '0;
    end else begin
      if (cap_active) begin
        wptr <= wptr + AW'(1);
      end
      if (trig_take) begin
        tptr <= wptr;
      end
    end
  end

  // Capture configuration, latched on an accepted arm so the inputs may
  // change freely during a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      mode_q  <= LEVEL;
    end else if (arm_ok) begin
      pre_q   <= pre_trig;
      mask_q  <= trig_mask;
      value_q <= trig_value;
      mode_q  <= trig_mode_e'(trig_mode);
    end
  end

  // Previous-cycle probe and level match for CHANGE/EDGE. The match history
  // is forced true on arm so a level already present cannot look like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_q <= '0;
      lvl_q   <= 1'b0;
    end else begin
      probe_q <= probe;
      lvl_q   <= arm_ok ? 1'b1 : lvl_now;
    end
  end

  // Status flags. Abort only has something to undo while a capture runs;
  // in IDLE it leaves a finished capture's flags alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      if (arm_ok) begin
        done_q <= 1'b0;
        trig_q <= 1'b0;
      end
      if (trig_take) begin
        trig_q <= 1'b1;
      end
      if (finish) begin
        done_q <= 1'b1;
      end
      if (abort && cap_active) begin
        done_q <= 1'b0;
        trig_q <= 1'b0;
      end
    end
  end

  // The RAM read register carries no reset, so readout is held at zero until
  // the first clock after reset has refreshed it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= 1'b1;
    end
  end

  probe_capture_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (cap_active),
    .waddr(wptr),
    .wdata(probe),
    .raddr(raddr),
    .rdata(ram_q)
  );

  assign rd_data   = rd_ok ? ram_q : '0;
  assign state     = state_q;
  assign triggered = trig_q;
  assign done      = done_q;
  assign trig_pos  = pre_q;

endmodule

// File: tb/tb_probe_capture.sv
// Self-checking bench for probe_capture with a 16-deep, 16-bit buffer.
// Expected buffer contents are queued as each capture is set up and popped
// during readout.
module tb_probe_capture;
  import probe_capture_pkg::*;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe;
  logic          arm;
  logic          abort;
  logic [AW-1:0] pre_trig;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic [1:0]    trig_mode;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [1:0]    state;
  logic          triggered;
  logic          done;
  logic [AW-1:0] trig_pos;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  probe_capture #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .probe     (probe),
    .arm       (arm),
    .abort     (abort),
    .pre_trig  (pre_trig),
    .trig_mask (trig_mask),
    .trig_value(trig_value),
    .trig_mode (trig_mode),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .state     (state),
    .triggered (triggered),
    .done      (done),
    .trig_pos  (trig_pos)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_capture(input logic [AW-1:0] pre, input logic [DW-1:0] m,
                             input logic [DW-1:0] v, input logic [1:0] mode);
    pre_trig   = pre;
    trig_mask  = m;
    trig_value = v;
    trig_mode  = mode;
    arm        = 1'b1;
    step();
    arm        = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests_run++;
    if (triggered !== 1'b0) begin tests_failed++; $display("FAIL reset_triggered: got %b expected 0", triggered); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++;
    if (trig_pos !== 4'd0) begin tests_failed++; $display("FAIL reset_trig_pos: got %0d expected 0", trig_pos); end
    tests_run++;
    if (rd_data !== 16'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
  endtask

  task automatic test_level();
    int tcyc = -1;
    int dcyc = -1;
    logic [DW-1:0] tsamp = '0;
    logic [DW-1:0] expv;
    exp_q.delete();
    for (int i = 0; i < DP; i++) exp_q.push_back(DW'(16'h1C + i));
    probe = 16'h10;
    arm_capture(4'd4, 16'h00FF, 16'h0020, LEVEL);
    tests_run++;
    if (state !== PRE) begin tests_failed++; $display("FAIL level_arm_state: got %0d expected %0d", state, PRE); end
    for (int k = 1; k <= 60 && dcyc < 0; k++) begin
      probe = DW'(16'h10 + k);
      step();
      if (triggered === 1'b1 && tcyc < 0) begin tcyc = k; tsamp = probe; end
      if (done === 1'b1) dcyc = k;
    end
    tests_run++;
    if (tsamp !== 16'h0020) begin tests_failed++; $display("FAIL level_trig_sample: got %h expected 0020", tsamp); end
    tests_run++;
    if (trig_pos !== 4'd4) begin tests_failed++; $display("FAIL level_trig_pos: got %0d expected 4", trig_pos); end
    tests_run++;
    if (dcyc - tcyc + 1 !== 12) begin tests_failed++; $display("FAIL level_done_delay: got %0d expected 12", dcyc - tcyc + 1); end
    tests_run++;
    if (state !== IDLE) begin tests_failed++; $display("FAIL level_end_state: got %0d expected 0", state); end
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      step();
      expv = exp_q.pop_front();
      tests_run++;
      if (rd_data !== expv) begin tests_failed++; $display("FAIL level_read[%0d]: got %h expected %h", i, rd_data, expv); end
    end
  endtask

  task automatic test_edge();
    int tcyc = -1;
    int dcyc = -1;
    logic [DW-1:0] expv;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0015);
    for (int i = 1; i <= 13; i++) exp_q.push_back(DW'(16'h100 + i));
    probe = 16'h05;
    step();
    step();
    arm_capture(4'd2, 16'h000F, 16'h0005, EDGE);
    for (int k = 1; k <= 80 && dcyc < 0; k++) begin
      if (k <= 20) probe = 16'h05;
      else if (k <= 23) probe = 16'h00;
      else if (k == 24) probe = 16'h15;
      else probe = DW'(16'h100 + (k - 24));
      step();
      if (triggered === 1'b1 && tcyc < 0) tcyc = k;
      if (done === 1'b1) dcyc = k;
      if (k == 20) begin
        tests_run++;
        if (state !== WAIT || triggered !== 1'b0) begin
          tests_failed++; $display("FAIL edge_held_level: state %0d triggered %b, expected state 2 triggered 0", state, triggered);
        end
      end
    end
    tests_run++;
    if (tcyc !== 24) begin tests_failed++; $display("FAIL edge_trig_cycle: got %0d expected 24", tcyc); end
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      step();
      expv = exp_q.pop_front();
      tests_run++;
      if (rd_data !== expv) begin tests_failed++; $display("FAIL edge_read[%0d]: got %h expected %h", i, rd_data, expv); end
    end
  endtask

  task automatic test_change();
    int tcyc = -1;
    int dcyc = -1;
    logic [DW-1:0] expv;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h00A1);
    exp_q.push_back(16'h00A0);
    for (int k = 41; k <= 52; k++) exp_q.push_back(DW'(16'h200 + k));
    probe = 16'hA0;
    arm_capture(4'd3, 16'h0001, 16'h0000, CHANGE);
    for (int k = 1; k <= 90 && dcyc < 0; k++) begin
      // bit0 flips on the last PRE cycle (must be ignored) and again on cycle 40
      if (k <= 2) probe = 16'hA0;
      else if (k <= 39) probe = 16'hA1;
      else if (k == 40) probe = 16'hA0;
      else probe = DW'(16'h200 + k);
      step();
      if (triggered === 1'b1 && tcyc < 0) tcyc = k;
      if (done === 1'b1) dcyc = k;
    end
    tests_run++;
    if (tcyc !== 40) begin tests_failed++; $display("FAIL change_trig_cycle: got %0d expected 40", tcyc); end
    tests_run++;
    if (trig_pos !== 4'd3) begin tests_failed++; $display("FAIL change_trig_pos: got %0d expected 3", trig_pos); end
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      step();
      expv = exp_q.pop_front();
      tests_run++;
      if (rd_data !== expv) begin tests_failed++; $display("FAIL change_read[%0d]: got %h expected %h", i, rd_data, expv); end
    end
  endtask

  task automatic test_immediate();
    int tcyc = -1;
    int dcyc = -1;
    logic [DW-1:0] expv;
    exp_q.delete();
    for (int i = 1; i <= DP; i++) exp_q.push_back(DW'(16'h300 + i));
    probe = 16'h300;
    arm_capture(4'd0, 16'h0000, 16'h0000, IMMEDIATE);
    tests_run++;
    if (state !== WAIT) begin tests_failed++; $display("FAIL imm_arm_state: got %0d expected 2", state); end
    for (int k = 1; k <= 40 && dcyc < 0; k++) begin
      probe = DW'(16'h300 + k);
      step();
      if (triggered === 1'b1 && tcyc < 0) tcyc = k;
      if (done === 1'b1) dcyc = k;
    end
    tests_run++;
    if (tcyc !== 1) begin tests_failed++; $display("FAIL imm_trig_cycle: got %0d expected 1", tcyc); end
    tests_run++;
    if (dcyc !== 16) begin tests_failed++; $display("FAIL imm_done_cycle: got %0d expected 16", dcyc); end
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      step();
      expv = exp_q.pop_front();
      tests_run++;
      if (rd_data !== expv) begin tests_failed++; $display("FAIL imm_read[%0d]: got %h expected %h", i, rd_data, expv); end
    end
  endtask

  task automatic test_full_pretrig_wrap();
    int tcyc = -1;
    int dcyc = -1;
    logic [DW-1:0] expv;
    exp_q.delete();
    for (int i = 0; i < DP; i++) exp_q.push_back(DW'(16'h42D + i));
    probe = 16'h400;
    arm_capture(4'd15, 16'hFFFF, 16'h043C, LEVEL);
    for (int k = 1; k <= 100 && dcyc < 0; k++) begin
      probe = DW'(16'h400 + k);
      step();
      if (triggered === 1'b1 && tcyc < 0) tcyc = k;
      if (done === 1'b1) dcyc = k;
    end
    tests_run++;
    if (tcyc !== 60) begin tests_failed++; $display("FAIL wrap_trig_cycle: got %0d expected 60", tcyc); end
    tests_run++;
    if (dcyc !== 60 || state !== IDLE) begin
      tests_failed++; $display("FAIL wrap_no_post: done cycle %0d state %0d, expected 60 and 0", dcyc, state);
    end
    tests_run++;
    if (trig_pos !== 4'd15) begin tests_failed++; $display("FAIL wrap_trig_pos: got %0d expected 15", trig_pos); end
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      step();
      expv = exp_q.pop_front();
      tests_run++;
      if (rd_data !== expv) begin tests_failed++; $display("FAIL wrap_read[%0d]: got %h expected %h", i, rd_data, expv); end
    end
  endtask

  task automatic test_abort();
    probe = 16'h60;
    arm_capture(4'd2, 16'h00FF, 16'h0077, LEVEL);
    for (int k = 1; k <= 22; k++) begin
      probe = DW'(16'h60 + k);
      step();
    end
    tests_run++;
    if (state !== WAIT) begin tests_failed++; $display("FAIL abort_pre_state: got %0d expected 2", state); end
    probe = 16'h77;
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (state !== IDLE) begin tests_failed++; $display("FAIL abort_state: got %0d expected 0", state); end
    tests_run++;
    if (triggered !== 1'b0) begin tests_failed++; $display("FAIL abort_triggered: got %b expected 0", triggered); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_done: got %b expected 0", done); end
    step();
    tests_run++;
    if (state !== IDLE) begin tests_failed++; $display("FAIL abort_stays_idle: got %0d expected 0", state); end
  endtask

  task automatic test_arm_in_post();
    int tcyc = -1;
    int dcyc = -1;
    logic [DW-1:0] expv;
    exp_q.delete();
    for (int i = 0; i < DP; i++) exp_q.push_back(DW'(16'h1C + i));
    probe = 16'h10;
    arm_capture(4'd4, 16'h00FF, 16'h0020, LEVEL);
    for (int k = 1; k <= 60 && dcyc < 0; k++) begin
      probe = DW'(16'h10 + k);
      if (tcyc > 0 && k == tcyc + 2) begin
        arm        = 1'b1;
        pre_trig   = 4'd9;
        trig_mode  = IMMEDIATE;
        trig_value = 16'h0;
      end
      step();
      if (arm === 1'b1) begin
        arm = 1'b0;
        tests_run++;
        if (state !== POST) begin tests_failed++; $display("FAIL post_arm_state: got %0d expected 3", state); end
      end
      if (triggered === 1'b1 && tcyc < 0) tcyc = k;
      if (done === 1'b1) dcyc = k;
    end
    tests_run++;
    if (trig_pos !== 4'd4) begin tests_failed++; $display("FAIL post_arm_trig_pos: got %0d expected 4", trig_pos); end
    tests_run++;
    if (tcyc !== 16 || dcyc !== 27) begin
      tests_failed++; $display("FAIL post_arm_timing: trig %0d done %0d, expected 16 and 27", tcyc, dcyc);
    end
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      step();
      expv = exp_q.pop_front();
      tests_run++;
      if (rd_data !== expv) begin tests_failed++; $display("FAIL post_arm_read[%0d]: got %h expected %h", i, rd_data, expv); end
    end
  endtask

  task automatic test_reset_in_post();
    probe = 16'h10;
    arm_capture(4'd4, 16'h00FF, 16'h0020, LEVEL);
    for (int k = 1; k <= 19; k++) begin
      probe = DW'(16'h10 + k);
      step();
    end
    tests_run++;
    if (state !== POST || triggered !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre_state: state %0d triggered %b, expected 3 and 1", state, triggered);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("FAIL rst_post_state: got %0d expected 0", state); end
    tests_run++;
    if (triggered !== 1'b0) begin tests_failed++; $display("FAIL rst_post_triggered: got %b expected 0", triggered); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_post_done: got %b expected 0", done); end
    tests_run++;
    if (trig_pos !== 4'd0) begin tests_failed++; $display("FAIL rst_post_trig_pos: got %0d expected 0", trig_pos); end
    tests_run++;
    if (rd_data !== 16'h0) begin tests_failed++; $display("FAIL rst_post_rd_data: got %h expected 0000", rd_data); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst        = 1'b1;
    arm        = 1'b0;
    abort      = 1'b0;
    probe      = '0;
    pre_trig   = '0;
    trig_mask  = '0;
    trig_value = '0;
    trig_mode  = 2'd0;
    rd_addr    = '0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_level();
    test_edge();
    test_change();
    test_immediate();
    test_full_pretrig_wrap();
    test_abort();
    test_arm_in_post();
    test_reset_in_post();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
